// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register map, control/status bit indices and control type
package multi_timer_pkg;
  localparam logic [2:0] REG_CNT = 3'd0;
  localparam logic [2:0] REG_ARR = 3'd1;
  localparam logic [2:0] REG_CTRL = 3'd2;
  localparam logic [2:0] REG_PSC = 3'd3;
  localparam logic [2:0] REG_CMP = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;
  localparam int CTRL_EN = 0;
  localparam int CTRL_DIR = 1;
  localparam int CTRL_ARM = 2;
  localparam int CTRL_UIE = 3;
  localparam int CTRL_CIE = 4;
  localparam int STAT_UIF = 0;
  localparam int STAT_CCIF = 1;
  localparam int STAT_EN = 2;
  typedef struct packed {
    logic cie;
    logic uie;
    logic arm;
    logic dir;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one prescaled up/down counter with shadowed reload, compare and W1C flags
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wr_arr,
  input  logic             wr_ctrl,
  input  logic             wr_psc,
  input  logic             wr_cmp,
  input  logic             wr_stat,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [2:0]       sel,
  output logic [31:0]      rd_val,
  output logic             irq_req
);
  ctrl_t ctrl;
  logic [PSC_W-1:0] psc, psc_cnt;
  logic [CNT_W-1:0] cnt, cnt_next, arr_sh, arr_act, cmp;
  logic uif, ccif, tick, upd, hit, en_rise;
  logic [31:0] stat;
  always_comb begin
    tick = ctrl.en && psc_cnt == psc;
    upd = tick && (ctrl.dir ? cnt == '0 : cnt == arr_act);
    hit = tick && cnt == cmp;
    en_rise = wr_ctrl && wr_data[CTRL_EN] && !ctrl.en;
    cnt_next = en_rise ? (wr_data[CTRL_DIR] ? arr_sh : '0) :
               !tick ? cnt :
               upd ? (!ctrl.arm ? cnt : ctrl.dir ? arr_act : '0) :
               ctrl.dir ? cnt - 1'b1 : cnt + 1'b1;
    stat = '0;
    stat[STAT_UIF] = uif;
    stat[STAT_CCIF] = ccif;
    stat[STAT_EN] = ctrl.en;
    rd_val = sel == REG_CNT  ? 32'(cnt) :
             sel == REG_ARR  ? 32'(arr_sh) :
             sel == REG_CTRL ? 32'(ctrl) :
             sel == REG_PSC  ? 32'(psc) :
             sel == REG_CMP  ? 32'(cmp) :
             sel == REG_STAT ? stat : '0;
    irq_req = (uif && ctrl.uie) || (ccif && ctrl.cie);
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ctrl <= '0;
      psc <= '0;
      psc_cnt <= '0;
      cnt <= '0;
      arr_sh <= '0;
      arr_act <= '0;
      cmp <= '0;
      uif <= 1'b0;
      ccif <= 1'b0;
    end else begin
      cnt <= cnt_next;
      psc_cnt <= (en_rise || tick) ? '0 : psc_cnt + PSC_W'(ctrl.en);
      if (!ctrl.en || upd) arr_act <= arr_sh;
      if (wr_arr) arr_sh <= wr_data;
      if (wr_psc) psc <= wr_data[PSC_W-1:0];
      if (wr_cmp) cmp <= wr_data;
      if (wr_ctrl) ctrl <= '{cie: wr_data[CTRL_CIE], uie: wr_data[CTRL_UIE], arm: wr_data[CTRL_ARM],
                            dir: wr_data[CTRL_DIR], en: wr_data[CTRL_EN]};
      else if (upd && !ctrl.arm) ctrl.en <= 1'b0;
      uif <= upd || (uif && !(wr_stat && wr_data[STAT_UIF]));
      ccif <= hit || (ccif && !(wr_stat && wr_data[STAT_CCIF]));
    end
  end
endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH timer channels behind one slot port with decode, errors and merged irq
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter int PSC_W = 16,
  localparam int ADDR_W = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              chip_select,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              rd_done,
  output logic              wr_done,
  output logic              idle,
  output logic              slave_error,
  output logic              decode_error,
  output logic              irq
);
  logic [31:0] ch, rd_mux;
  logic [2:0] sel;
  logic acc, wr, rd, wr_ok;
  logic [31:0] rd_val [NUM_CH];
  logic [NUM_CH-1:0] irq_req;
  always_comb begin
    sel = addr[2:0];
    ch = 32'(addr >> 3);
    acc = chip_select && (read || write);
    wr = chip_select && write;
    rd = chip_select && read && !write;
    decode_error = acc && (ch >= NUM_CH || sel > REG_STAT);
    slave_error = wr && !decode_error && sel == REG_CNT;
    wr_ok = wr && !decode_error && !slave_error;
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) if (ch == i) rd_mux = rd_val[i];
    rd_done = rd;
    rd_data = (rd && !decode_error) ? rd_mux : '0;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W), .PSC_W(PSC_W)) u_ch (
      .clk(clk),
      .arst(arst),
      .wr_arr(wr_ok && ch == c && sel == REG_ARR),
      .wr_ctrl(wr_ok && ch == c && sel == REG_CTRL),
      .wr_psc(wr_ok && ch == c && sel == REG_PSC),
      .wr_cmp(wr_ok && ch == c && sel == REG_CMP),
      .wr_stat(wr_ok && ch == c && sel == REG_STAT),
      .wr_data(wr_data[CNT_W-1:0]),
      .sel(sel),
      .rd_val(rd_val[c]),
      .irq_req(irq_req[c])
    );
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_done <= 1'b0;
      idle <= 1'b1;
      irq <= 1'b0;
    end else begin
      wr_done <= wr;
      idle <= !acc;
      irq <= |irq_req;
    end
  end
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed self-checking bench for multi_timer with three channels
module tb_multi_timer;
  import multi_timer_pkg::*;
  logic clk = 1'b0, arst = 1'b1, chip_select = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] wr_data = '0, rd_data;
  logic rd_done, wr_done, idle, slave_error, decode_error, irq;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  multi_timer #(.NUM_CH(3)) dut (
    .clk(clk), .arst(arst), .chip_select(chip_select), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rd_done(rd_done), .wr_done(wr_done),
    .idle(idle), .slave_error(slave_error), .decode_error(decode_error), .irq(irq)
  );
  task automatic bus_write(input logic [1:0] c, input logic [2:0] r, input logic [31:0] d);
    chip_select = 1'b1; write = 1'b1; read = 1'b0; addr = {c, r}; wr_data = d;
    @(posedge clk); #1;
    chip_select = 1'b0; write = 1'b0; wr_data = '0;
  endtask
  task automatic bus_read(input logic [1:0] c, input logic [2:0] r, output logic [31:0] d);
    chip_select = 1'b1; read = 1'b1; write = 1'b0; addr = {c, r};
    #1 d = rd_data;
    @(posedge clk); #1;
    chip_select = 1'b0; read = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", idle); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL rst_wr_done: got %b expected 0", wr_done); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_rd_data: got %0h expected 0", rd_data); end
    checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL rst_rd_done: got %b expected 0", rd_done); end
    checks++; if ({slave_error, decode_error} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b expected 00", {slave_error, decode_error}); end
    arst = 1'b0;
    bus_read(2'd1, REG_PSC, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_psc: got %0h expected 0", d); end
    bus_read(2'd0, REG_ARR, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_arr: got %0h expected 0", d); end
    bus_read(2'd2, REG_STAT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_stat: got %0h expected 0", d); end
  endtask
  task automatic test_up_reload;
    logic [31:0] d;
    bus_write(2'd0, REG_ARR, 32'd3);
    bus_write(2'd0, REG_CMP, 32'd7);
    bus_write(2'd0, REG_CTRL, 32'b01101);
    for (int c = 0; c < 5; c++) begin
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL up_irq_low c=%0d: got %b expected 0", c, irq); end
      bus_read(2'd0, REG_CNT, d);
      checks++; if (d !== 32'(c % 4)) begin errors++; $display("FAIL up_cnt c=%0d: got %0h expected %0h", c, d, c % 4); end
    end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL up_irq_high: got %b expected 1", irq); end
    bus_read(2'd0, REG_STAT, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL up_stat: got %0h expected 5", d); end
    bus_write(2'd0, REG_CTRL, 32'b01100);
    bus_write(2'd0, REG_STAT, 32'd1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL up_irq_after_w1c: got %b expected 1", irq); end
    step(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL up_irq_dropped: got %b expected 0", irq); end
    bus_read(2'd0, REG_STAT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL up_stat_clear: got %0h expected 0", d); end
    bus_read(2'd0, REG_CNT, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL up_cnt_hold: got %0h expected 3", d); end
  endtask
  task automatic test_psc_compare;
    logic [31:0] d;
    bus_write(2'd1, REG_PSC, 32'd2);
    bus_write(2'd1, REG_ARR, 32'd9);
    bus_write(2'd1, REG_CMP, 32'd4);
    bus_write(2'd1, REG_CTRL, 32'b10101);
    for (int c = 0; c < 17; c++) begin
      checks++; if (irq !== (c >= 16)) begin errors++; $display("FAIL psc_irq c=%0d: got %b expected %b", c, irq, c >= 16); end
      bus_read(2'd1, REG_CNT, d);
      checks++; if (d !== 32'(c / 3)) begin errors++; $display("FAIL psc_cnt c=%0d: got %0h expected %0h", c, d, c / 3); end
    end
    bus_read(2'd1, REG_STAT, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL psc_stat_ccif: got %0h expected 6", d); end
    step(11);
    bus_read(2'd1, REG_STAT, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL psc_stat_at9: got %0h expected 6", d); end
    bus_read(2'd1, REG_STAT, d);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL psc_stat_uif: got %0h expected 7", d); end
    bus_read(2'd1, REG_CNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL psc_cnt_wrap: got %0h expected 0", d); end
    bus_write(2'd1, REG_CTRL, 32'd0);
    bus_write(2'd1, REG_STAT, 32'd3);
  endtask
  task automatic test_oneshot_down;
    logic [31:0] d;
    bus_write(2'd2, REG_ARR, 32'd5);
    bus_write(2'd2, REG_CMP, 32'd3);
    bus_write(2'd2, REG_CTRL, 32'b00011);
    for (int c = 0; c < 6; c++) begin
      bus_read(2'd2, REG_CNT, d);
      checks++; if (d !== 32'(5 - c)) begin errors++; $display("FAIL os_cnt c=%0d: got %0h expected %0h", c, d, 5 - c); end
    end
    bus_read(2'd2, REG_CTRL, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL os_ctrl_en_clear: got %0h expected 2", d); end
    bus_read(2'd2, REG_CNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_cnt_hold: got %0h expected 0", d); end
    bus_read(2'd2, REG_STAT, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL os_stat: got %0h expected 3", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL os_irq: got %b expected 0", irq); end
  endtask
  task automatic test_shadow;
    logic [31:0] d;
    bus_write(2'd0, REG_ARR, 32'd10);
    bus_write(2'd0, REG_CTRL, 32'b00101);
    for (int c = 0; c < 4; c++) begin
      bus_read(2'd0, REG_CNT, d);
      checks++; if (d !== 32'(c)) begin errors++; $display("FAIL sh_cnt c=%0d: got %0h expected %0h", c, d, c); end
    end
    bus_write(2'd0, REG_ARR, 32'd2);
    for (int c = 5; c < 16; c++) begin
      int e;
      e = (c <= 10) ? c : (c - 11) % 3;
      bus_read(2'd0, REG_CNT, d);
      checks++; if (d !== 32'(e)) begin errors++; $display("FAIL sh_cnt c=%0d: got %0h expected %0h", c, d, e); end
    end
    bus_write(2'd0, REG_CTRL, 32'd0);
    bus_write(2'd0, REG_STAT, 32'd3);
  endtask
  task automatic test_errors;
    logic [31:0] d;
    chip_select = 1'b1; write = 1'b1; addr = {2'd0, REG_CNT}; wr_data = 32'hAA;
    #1;
    checks++; if (slave_error !== 1'b1) begin errors++; $display("FAIL err_slave: got %b expected 1", slave_error); end
    checks++; if (decode_error !== 1'b0) begin errors++; $display("FAIL err_slave_dec: got %b expected 0", decode_error); end
    @(posedge clk); #1;
    chip_select = 1'b0; write = 1'b0; wr_data = '0;
    checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL err_wr_done: got %b expected 1", wr_done); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL err_idle_busy: got %b expected 0", idle); end
    step(1);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL err_idle_back: got %b expected 1", idle); end
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL err_wr_done_low: got %b expected 0", wr_done); end
    bus_read(2'd0, REG_CNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL err_cnt_unchanged: got %0h expected 0", d); end
    chip_select = 1'b1; read = 1'b1; addr = {2'd0, 3'd6};
    #1;
    checks++; if (decode_error !== 1'b1) begin errors++; $display("FAIL dec_reg6: got %b expected 1", decode_error); end
    checks++; if (rd_done !== 1'b1) begin errors++; $display("FAIL dec_reg6_done: got %b expected 1", rd_done); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL dec_reg6_data: got %0h expected 0", rd_data); end
    checks++; if (slave_error !== 1'b0) begin errors++; $display("FAIL dec_reg6_slave: got %b expected 0", slave_error); end
    @(posedge clk); #1;
    addr = {2'd3, REG_ARR};
    #1;
    checks++; if (decode_error !== 1'b1) begin errors++; $display("FAIL dec_ch3: got %b expected 1", decode_error); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL dec_ch3_data: got %0h expected 0", rd_data); end
    @(posedge clk); #1;
    chip_select = 1'b0; read = 1'b0;
    bus_write(2'd1, REG_CTRL, 32'hFFFF_FFE0);
    bus_read(2'd1, REG_CTRL, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL w_ctrl_trunc: got %0h expected 0", d); end
    bus_write(2'd1, REG_PSC, 32'h0001_2345);
    bus_read(2'd1, REG_PSC, d);
    checks++; if (d !== 32'h2345) begin errors++; $display("FAIL w_psc_trunc: got %0h expected 2345", d); end
    bus_write(2'd2, REG_STAT, 32'd4);
    bus_read(2'd2, REG_STAT, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL w_stat_en_ignored: got %0h expected 3", d); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] d;
    bus_write(2'd2, REG_STAT, 32'd3);
    bus_write(2'd2, REG_ARR, 32'd2);
    bus_write(2'd2, REG_CTRL, 32'b00111);
    step(2);
    bus_write(2'd2, REG_STAT, 32'd1);
    bus_read(2'd2, REG_STAT, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL race_set_wins: got %0h expected 5", d); end
    bus_read(2'd2, REG_CNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL race_reload: got %0h expected 1", d); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] d;
    bus_write(2'd2, REG_CTRL, 32'b01111);
    bus_write(2'd1, REG_CMP, 32'd7);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_before: got %b expected 1", irq); end
    checks++; if (wr_done !== 1'b1) begin errors++; $display("FAIL mid_wr_done_before: got %b expected 1", wr_done); end
    #3 arst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected 0", irq); end
    checks++; if (wr_done !== 1'b0) begin errors++; $display("FAIL mid_wr_done: got %b expected 0", wr_done); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b expected 1", idle); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL mid_rd_data: got %0h expected 0", rd_data); end
    @(negedge clk) arst = 1'b0;
    @(posedge clk); #1;
    bus_read(2'd2, REG_CTRL, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_ctrl: got %0h expected 0", d); end
    bus_read(2'd1, REG_CMP, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_cmp: got %0h expected 0", d); end
    bus_read(2'd2, REG_STAT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_stat: got %0h expected 0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq_after: got %b expected 0", irq); end
  endtask
  initial begin
    test_reset;
    test_up_reload;
    test_psc_compare;
    test_oneshot_down;
    test_shadow;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
